// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 8/4 restoring divider.
package div_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int CNT_W      = 4;

  localparam logic [DIVIDEND_W-1:0] DZ_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract B.
module div_restore_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] rem_in,
  input  logic                 din_bit,
  input  logic [DIVISOR_W-1:0] B,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 qbit
);

  logic [DIVISOR_W:0] rs;
  logic [DIVISOR_W:0] bx;

  always_comb begin
    rs   = {rem_in, din_bit};
    bx   = {1'b0, B};
    qbit = (rs >= bx);
    // rem < B <= 15 after a subtract, so the top bit is always zero
    rem_out = qbit ? DIVISOR_W'(rs - bx) : rs[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/div_8x4_seq.sv
// Sequential 8/4 unsigned restoring divider with optional skipped
// low quotient bits and a start/busy/done handshake.
module div_8x4_seq
  import div_pkg::*;
#(
  parameter int APPRX_BITS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] A,
  input  logic [DIVISOR_W-1:0]  B,
  output logic [DIVIDEND_W-1:0] Q,
  output logic [DIVISOR_W-1:0]  R,
  output logic                  busy,
  output logic                  done,
  output logic                  dz
);

  localparam int N_ITER = DIVIDEND_W - APPRX_BITS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ITER - 1);

  generate
    if (APPRX_BITS < 0 || APPRX_BITS > 4) begin : g_bad_k
      $error("div_8x4_seq: APPRX_BITS must be within 0..4");
    end
  endgenerate

  state_t                state;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVIDEND_W-1:0] qacc;
  logic [DIVISOR_W-1:0]  rem;
  logic [DIVISOR_W-1:0]  b_q;
  logic [CNT_W-1:0]      cnt;
  logic [DIVISOR_W-1:0]  rem_nxt;
  logic                  qbit;
  logic [DIVIDEND_W-1:0] q_full;

  // dvd holds A >> k right-aligned, so the next bit sits at N_ITER-1
  div_restore_step u_step (
    .rem_in  (rem),
    .din_bit (dvd[N_ITER-1]),
    .B       (b_q),
    .rem_out (rem_nxt),
    .qbit    (qbit)
  );

  assign q_full = {qacc[DIVIDEND_W-2:0], qbit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dvd   <= '0;
      qacc  <= '0;
      rem   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            b_q  <= B;
            dvd  <= A >> APPRX_BITS;
            rem  <= '0;
            cnt  <= '0;
            qacc <= '0;
            if (B == '0) begin
              Q     <= DZ_QUOTIENT;
              R     <= A[DIVISOR_W-1:0];
              dz    <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem  <= rem_nxt;
          qacc <= q_full;
          dvd  <= {dvd[DIVIDEND_W-2:0], 1'b0};
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            dz    <= 1'b0;
            Q     <= q_full << APPRX_BITS;
            R     <= rem_nxt;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_8x4_seq.sv
// Directed bench for div_8x4_seq: exact (k=0) and approximate (k=2)
// instances share the same stimulus and are checked side by side.
module tb_div_8x4_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [3:0] b = '0;

  logic [1:0][7:0] qv;
  logic [1:0][3:0] rv;
  logic [1:0]      busyv;
  logic [1:0]      donev;
  logic [1:0]      dzv;

  int total = 0;
  int passed = 0;
  int fails = 0;

  int         dcyc[2];
  int         dcnt[2];
  int         bcnt[2];
  int         bfirst[2];
  int         blast[2];
  int         early[2];
  logic [7:0] qc[2];
  logic [7:0] qprev[2];
  logic [3:0] rc[2];
  logic       dzc[2];
  logic       bdone[2];

  always #5 clk = ~clk;

  div_8x4_seq #(.APPRX_BITS(0)) u_k0 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .Q     (qv[0]),
    .R     (rv[0]),
    .busy  (busyv[0]),
    .done  (donev[0]),
    .dz    (dzv[0])
  );

  div_8x4_seq #(.APPRX_BITS(2)) u_k2 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .Q     (qv[1]),
    .R     (rv[1]),
    .busy  (busyv[1]),
    .done  (donev[1]),
    .dz    (dzv[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) qprev[i] = qv[i];
  endtask

  task automatic issue(input logic [7:0] x, input logic [3:0] y);
    @(negedge clk);
    snap();
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 4'($urandom);
  endtask

  // Watches 14 cycles after the accepting edge; cycle 1 is the first.
  task automatic observe(input int restart_at);
    for (int i = 0; i < 2; i++) begin
      dcyc[i] = 0; dcnt[i] = 0; bcnt[i] = 0;
      bfirst[i] = 0; blast[i] = 0; early[i] = 0;
      qc[i] = '0; rc[i] = '0; dzc[i] = 1'b0; bdone[i] = 1'b0;
    end
    for (int c = 1; c <= 14; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (busyv[i]) begin
          bcnt[i]++;
          if (bfirst[i] == 0) bfirst[i] = c;
          blast[i] = c;
        end
        if (donev[i]) begin
          dcnt[i]++;
          if (dcyc[i] == 0) begin
            dcyc[i] = c;
            qc[i] = qv[i];
            rc[i] = rv[i];
            dzc[i] = dzv[i];
            bdone[i] = busyv[i];
          end
        end else if (dcyc[i] == 0 && qv[i] !== qprev[i]) begin
          early[i]++;
        end
      end
      if (c == restart_at) begin
        a = 8'd1;
        b = 4'd1;
        start = 1'b1;
      end else if (c == restart_at + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic expect_op(input int i, input string tag,
                           input logic [7:0] q, input logic [3:0] r,
                           input logic z, input int lat, input int nb);
    string t;
    t = $sformatf("%s_k%0d", tag, i * 2);
    chk({t, "_ndone"}, dcnt[i], 1);
    chk({t, "_lat"}, dcyc[i], lat);
    chk({t, "_q"}, qc[i], q);
    chk({t, "_r"}, rc[i], r);
    chk({t, "_dz"}, dzc[i], z);
    chk({t, "_nbusy"}, bcnt[i], nb);
    chk({t, "_busy_at_done"}, bdone[i], 0);
    chk({t, "_q_held"}, early[i], 0);
    if (nb > 0) begin
      chk({t, "_busy_first"}, bfirst[i], 1);
      chk({t, "_busy_last"}, blast[i], nb);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_q_k%0d", tag, i * 2), qv[i], 0);
      chk($sformatf("%s_r_k%0d", tag, i * 2), rv[i], 0);
      chk($sformatf("%s_busy_k%0d", tag, i * 2), busyv[i], 0);
      chk($sformatf("%s_done_k%0d", tag, i * 2), donev[i], 0);
      chk($sformatf("%s_dz_k%0d", tag, i * 2), dzv[i], 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    issue(8'd200, 4'd7);
    observe(0);
    expect_op(0, "t1", 8'd28, 4'd4, 1'b0, 9, 8);
    expect_op(1, "t1", 8'd28, 4'd1, 1'b0, 7, 6);

    issue(8'd255, 4'd15);
    observe(0);
    expect_op(0, "t2a", 8'd17, 4'd0, 1'b0, 9, 8);
    expect_op(1, "t2a", 8'd16, 4'd3, 1'b0, 7, 6);

    issue(8'd5, 4'd9);
    observe(0);
    expect_op(0, "t2b", 8'd0, 4'd5, 1'b0, 9, 8);
    expect_op(1, "t2b", 8'd0, 4'd1, 1'b0, 7, 6);

    issue(8'd0, 4'd1);
    observe(0);
    expect_op(0, "t2c", 8'd0, 4'd0, 1'b0, 9, 8);
    expect_op(1, "t2c", 8'd0, 4'd0, 1'b0, 7, 6);

    issue(8'd100, 4'd3);
    observe(0);
    expect_op(0, "t3", 8'd33, 4'd1, 1'b0, 9, 8);
    expect_op(1, "t3", 8'd32, 4'd1, 1'b0, 7, 6);

    issue(8'd77, 4'd0);
    observe(0);
    expect_op(0, "t4dz", 8'hFF, 4'hD, 1'b1, 1, 0);
    expect_op(1, "t4dz", 8'hFF, 4'hD, 1'b1, 1, 0);

    issue(8'd9, 4'd3);
    observe(0);
    expect_op(0, "t4n", 8'd3, 4'd0, 1'b0, 9, 8);
    expect_op(1, "t4n", 8'd0, 4'd2, 1'b0, 7, 6);

    issue(8'd200, 4'd7);
    observe(4);
    expect_op(0, "t5", 8'd28, 4'd4, 1'b0, 9, 8);
    expect_op(1, "t5", 8'd28, 4'd1, 1'b0, 7, 6);

    issue(8'd200, 4'd7);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("t6rst");
    @(negedge clk);
    rst = 1'b0;
    snap();
    observe(0);
    chk("t6_nodone_k0", dcnt[0], 0);
    chk("t6_nodone_k2", dcnt[1], 0);
    chk("t6_nobusy_k0", bcnt[0], 0);
    chk("t6_nobusy_k2", bcnt[1], 0);

    issue(8'd64, 4'd8);
    observe(0);
    expect_op(0, "t6", 8'd8, 4'd0, 1'b0, 9, 8);
    expect_op(1, "t6", 8'd8, 4'd0, 1'b0, 7, 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
